// File: rtl/rt_block_streamer_pkg.sv
// Shared state encoding and header layout for the real-time block streamer.
package rt_block_streamer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_TRIG    = 3'd1,
    ST_WAIT_HI = 3'd2,
    ST_WAIT_LO = 3'd3,
    ST_HDR     = 3'd4,
    ST_DATA    = 3'd5,
    ST_CSUM    = 3'd6
  } state_t;

  localparam int DATA_W    = 32;
  localparam int QUAD_W    = 6;
  localparam int SEQ_W     = 16;
  localparam int HDR_PAD_W = DATA_W - SEQ_W - QUAD_W;

  // Header quadlet: stream sequence number on top, quadlet count at the bottom.
  function automatic logic [DATA_W-1:0] make_header(input logic [SEQ_W-1:0]  seq,
                                                    input logic [QUAD_W-1:0] len);
    return {seq, {HDR_PAD_W{1'b0}}, len};
  endfunction

endpackage

// File: rtl/rt_block_streamer_csum.sv
// Running modulo-2^32 checksum accumulator for one stream.
module rt_csum_acc
  import rt_block_streamer_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clear,
  input  logic              i_add_en,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_sum
);

  logic [DATA_W-1:0] r_sum;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sum <= '0;
    end else if (i_clear) begin
      r_sum <= '0;
    end else if (i_add_en) begin
      r_sum <= r_sum + i_data;
    end
  end

  assign o_sum = r_sum;

endmodule

// File: rtl/rt_block_streamer.sv
// Real-time block streamer: triggers the sampler, waits for it to finish, then
// streams a header, the sampled quadlets and a checksum quadlet.
module rt_block_streamer
  import rt_block_streamer_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16,
  parameter int MAX_QUAD    = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [QUAD_W-1:0] i_num_quad,
  output logic              o_doSample,
  input  logic              i_isBusy,
  output logic [QUAD_W-1:0] o_blk_addr,
  input  logic [DATA_W-1:0] i_blk_data,
  output logic [DATA_W-1:0] o_tx_data,
  output logic              o_tx_valid,
  input  logic              i_tx_ready,
  output logic              o_tx_last,
  output logic              o_busy,
  output logic              o_err_timeout,
  output logic              o_err_len,
  output logic [SEQ_W-1:0]  o_seq
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  state_t            r_state;
  logic [QUAD_W-1:0] r_len;
  logic [QUAD_W-1:0] r_qidx;
  logic [QUAD_W-1:0] r_blk_addr;
  logic [TMO_W-1:0]  r_tmo;
  logic [DATA_W-1:0] r_tx_data;
  logic              r_doSample;
  logic              r_tx_valid;
  logic              r_tx_last;
  logic              r_busy;
  logic              r_err_timeout;
  logic              r_err_len;
  logic [SEQ_W-1:0]  r_seq;

  logic              w_len_ok;
  logic              w_tmo_hit;
  logic              w_csum_clr;
  logic              w_csum_add;
  logic [DATA_W-1:0] w_sum;

  assign w_len_ok   = (i_num_quad != '0) && (int'(i_num_quad) <= MAX_QUAD);
  assign w_tmo_hit  = (r_tmo == TMO_W'(TIMEOUT_CYC - 1));
  assign w_csum_clr = (r_state == ST_TRIG);
  assign w_csum_add = r_tx_valid && i_tx_ready && ((r_state == ST_HDR) || (r_state == ST_DATA));

  // The accumulator adds whatever quadlet is on tx_data at the moment it is accepted.
  rt_csum_acc u_csum (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clear  (w_csum_clr),
    .i_add_en (w_csum_add),
    .i_data   (r_tx_data),
    .o_sum    (w_sum)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= ST_IDLE;
      r_len         <= '0;
      r_qidx        <= '0;
      r_blk_addr    <= '0;
      r_tmo         <= '0;
      r_tx_data     <= '0;
      r_doSample    <= 1'b0;
      r_tx_valid    <= 1'b0;
      r_tx_last     <= 1'b0;
      r_busy        <= 1'b0;
      r_err_timeout <= 1'b0;
      r_err_len     <= 1'b0;
      r_seq         <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            if (w_len_ok) begin
              r_len         <= i_num_quad;
              r_err_len     <= 1'b0;
              r_err_timeout <= 1'b0;
              r_doSample    <= 1'b1;
              r_busy        <= 1'b1;
              r_state       <= ST_TRIG;
            end else begin
              r_err_len <= 1'b1;
            end
          end
        end
        ST_TRIG: begin
          r_doSample <= 1'b0;
          r_tmo      <= '0;
          r_state    <= ST_WAIT_HI;
        end
        // The timeout budget is shared by both wait phases.
        ST_WAIT_HI: begin
          r_tmo <= r_tmo + 1'b1;
          if (i_isBusy) begin
            r_state <= ST_WAIT_LO;
          end else if (w_tmo_hit) begin
            r_err_timeout <= 1'b1;
            r_busy        <= 1'b0;
            r_state       <= ST_IDLE;
          end
        end
        ST_WAIT_LO: begin
          r_tmo <= r_tmo + 1'b1;
          if (!i_isBusy) begin
            r_tx_data  <= make_header(r_seq, r_len);
            r_tx_valid <= 1'b1;
            r_blk_addr <= '0;
            r_state    <= ST_HDR;
          end else if (w_tmo_hit) begin
            r_err_timeout <= 1'b1;
            r_busy        <= 1'b0;
            r_state       <= ST_IDLE;
          end
        end
        // blk_addr always points at the quadlet to load on the next acceptance.
        ST_HDR: begin
          if (i_tx_ready) begin
            r_tx_data  <= i_blk_data;
            r_blk_addr <= r_blk_addr + QUAD_W'(1);
            r_qidx     <= '0;
            r_state    <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (i_tx_ready) begin
            if (r_qidx == r_len - QUAD_W'(1)) begin
              r_tx_data <= w_sum + r_tx_data;
              r_tx_last <= 1'b1;
              r_state   <= ST_CSUM;
            end else begin
              r_tx_data  <= i_blk_data;
              r_blk_addr <= r_blk_addr + QUAD_W'(1);
              r_qidx     <= r_qidx + QUAD_W'(1);
            end
          end
        end
        ST_CSUM: begin
          if (i_tx_ready) begin
            r_seq      <= r_seq + 1'b1;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_tx_last  <= 1'b0;
            r_blk_addr <= '0;
            r_busy     <= 1'b0;
            r_state    <= ST_IDLE;
          end
        end
        default: begin
          r_doSample <= 1'b0;
          r_tx_valid <= 1'b0;
          r_tx_last  <= 1'b0;
          r_busy     <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_doSample    = r_doSample;
  assign o_blk_addr    = r_blk_addr;
  assign o_tx_data     = r_tx_data;
  assign o_tx_valid    = r_tx_valid;
  assign o_tx_last     = r_tx_last;
  assign o_busy        = r_busy;
  assign o_err_timeout = r_err_timeout;
  assign o_err_len     = r_err_len;
  assign o_seq         = r_seq;

endmodule

// File: tb/tb_rt_block_streamer.sv
// Randomized scoreboard bench for rt_block_streamer: expected streams are built
// from the stream rules and popped by an independent monitor on every accepted quadlet.
module tb_rt_block_streamer;

  localparam int TIMEOUT_CYC = 16;
  localparam int MAX_QUAD    = 32;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  numQuad = 6'd0;
  logic        isBusy = 1'b0;
  logic        txReady = 1'b1;
  logic        doSample, txValid, txLast, busy, errTimeout, errLen;
  logic [5:0]  blkAddr;
  logic [31:0] blkData, txData;
  logic [15:0] seq;

  logic [31:0] mem [64];
  beat_t       expQ [$];
  logic [15:0] modelSeq = 16'd0;

  int checkCount = 0;
  int passCount = 0;
  int cycleNo = 0;
  int beatIdx = 0;
  int acceptCount = 0;
  int validCount = 0;
  int doSampleCount = 0;
  int validStartCycle = 0;
  int lastAcceptCycle = 0;
  int samplerBusyLen = 5;
  bit samplerOn = 1'b1;
  bit readyRand = 1'b0;

  bit          prevValid = 1'b0;
  bit          prevStall = 1'b0;
  logic        prevLast = 1'b0;
  logic [31:0] prevData = 32'd0;
  logic [5:0]  prevAddr = 6'd0;
  logic [31:0] firstData = 32'd0;

  rt_block_streamer #(.TIMEOUT_CYC(TIMEOUT_CYC), .MAX_QUAD(MAX_QUAD)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_start       (start),
    .i_num_quad    (numQuad),
    .o_doSample    (doSample),
    .i_isBusy      (isBusy),
    .o_blk_addr    (blkAddr),
    .i_blk_data    (blkData),
    .o_tx_data     (txData),
    .o_tx_valid    (txValid),
    .i_tx_ready    (txReady),
    .o_tx_last     (txLast),
    .o_busy        (busy),
    .o_err_timeout (errTimeout),
    .o_err_len     (errLen),
    .o_seq         (seq)
  );

  assign blkData = mem[blkAddr];

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cycleNo++;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checkCount++;
    if (act === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference stream: header, the first len buffer words, then their running sum.
  task automatic pushExpected(input int len);
    beat_t       b;
    logic [31:0] sum;
    b.data = {modelSeq, 10'd0, 6'(len)};
    b.last = 1'b0;
    sum = b.data;
    expQ.push_back(b);
    for (int k = 0; k < len; k++) begin
      b.data = mem[k];
      b.last = 1'b0;
      sum = sum + mem[k];
      expQ.push_back(b);
    end
    b.data = sum;
    b.last = 1'b1;
    expQ.push_back(b);
    modelSeq = modelSeq + 16'd1;
  endtask

  // Sampler model: goes busy right after a trigger pulse for samplerBusyLen cycles.
  initial forever begin
    @(posedge clk);
    #1;
    if (doSample && samplerOn) begin
      isBusy = 1'b1;
      repeat (samplerBusyLen) @(posedge clk);
      #1 isBusy = 1'b0;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    txReady = readyRand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: compares every accepted quadlet against the scoreboard and checks stall stability.
  initial begin : monitor
    beat_t b;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prevValid = 1'b0;
        prevStall = 1'b0;
        beatIdx   = 0;
      end else begin
        if (doSample) doSampleCount++;
        if (txValid) begin
          validCount++;
          if (!prevValid) validStartCycle = cycleNo;
          if (prevStall) begin
            checkOutput("stall_data_hold", txData, prevData);
            checkOutput("stall_last_hold", txLast, prevLast);
            checkOutput("stall_addr_hold", blkAddr, prevAddr);
          end
          if (txReady) begin
            if (expQ.size() == 0) begin
              checkCount++;
              $display("[TB] FAIL unexpected_beat: got 0x%0h, expected no quadlet", txData);
            end else begin
              b = expQ.pop_front();
              if (beatIdx == 0) firstData = txData;
              checkOutput("beat_data", txData, b.data);
              checkOutput("beat_last", txLast, b.last);
              beatIdx = b.last ? 0 : beatIdx + 1;
              acceptCount++;
              if (txLast) lastAcceptCycle = cycleNo;
            end
          end
        end
        prevValid = txValid;
        prevStall = txValid && !txReady;
        prevData  = txData;
        prevLast  = txLast;
        prevAddr  = blkAddr;
      end
    end
  end

  task automatic applyStimulus(input int len, input int busyLen, input bit randRdy,
                               input bit newMem, input bit poke);
    int guard;
    int acc0;
    if (newMem) for (int i = 0; i < 64; i++) mem[i] = $urandom;
    samplerOn      = 1'b1;
    samplerBusyLen = busyLen;
    pushExpected(len);
    doSampleCount = 0;
    acc0 = acceptCount;
    @(posedge clk);
    #1;
    start   = 1'b1;
    numQuad = 6'(len);
    readyRand = randRdy;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    checkOutput("busy_after_start", busy, 1);
    checkOutput("errs_cleared", {errTimeout, errLen}, 0);
    guard = 0;
    while (expQ.size() != 0 && guard < 3000) begin
      @(posedge clk);
      #1;
      guard++;
      if (poke && guard == 3) begin
        start   = 1'b1;
        numQuad = 6'd0;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    readyRand = 1'b0;
    checkOutput("stream_done", expQ.size(), 0);
    expQ.delete();
    @(negedge clk);
    checkOutput("idle_after_stream", busy, 0);
    checkOutput("seq_after_stream", seq, modelSeq);
    checkOutput("dosample_pulses", doSampleCount, 1);
    checkOutput("beats_per_stream", acceptCount - acc0, len + 2);
    checkOutput("err_len_untouched", errLen, 0);
    if (!randRdy) checkOutput("zero_bubble_span", lastAcceptCycle - validStartCycle + 1, len + 2);
  endtask

  initial begin : stimulus
    int badLens [2];
    int busyCnt;
    int v0;
    int guard;
    badLens[0] = 0;
    badLens[1] = 33;
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;

    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_ctrl", {doSample, txValid, txLast, busy, errTimeout, errLen}, 0);
    checkOutput("reset_data", txData, 0);
    checkOutput("reset_addr", blkAddr, 0);
    checkOutput("reset_seq", seq, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;

    $display("[TB] scenario 1: 28 quadlets, ready high");
    applyStimulus(28, 5, 1'b0, 1'b1, 1'b0);
    checkOutput("s1_header", firstData, 32'h0000_001C);

    $display("[TB] scenario 2: same buffer, random ready");
    applyStimulus(28, 5, 1'b1, 1'b0, 1'b0);
    checkOutput("s2_header", firstData, 32'h0001_001C);

    $display("[TB] random streams with start poked mid-stream");
    for (int n = 0; n < 4; n++) begin
      applyStimulus(int'($urandom_range(1, MAX_QUAD)), int'($urandom_range(2, 6)),
                    1'($urandom_range(0, 1)), 1'b1, 1'b1);
    end
    applyStimulus(1, 2, 1'b0, 1'b1, 1'b0);
    applyStimulus(MAX_QUAD, 3, 1'b1, 1'b1, 1'b0);

    $display("[TB] scenario 3: sampler never responds");
    samplerOn = 1'b0;
    doSampleCount = 0;
    v0 = validCount;
    @(posedge clk);
    #1;
    start   = 1'b1;
    numQuad = 6'd8;
    @(posedge clk);
    #1 start = 1'b0;
    busyCnt = 0;
    repeat (60) begin
      @(negedge clk);
      if (busy) busyCnt++;
    end
    checkOutput("timeout_busy_cycles", busyCnt, TIMEOUT_CYC + 1);
    checkOutput("timeout_flag", errTimeout, 1);
    checkOutput("timeout_idle", busy, 0);
    checkOutput("timeout_seq", seq, modelSeq);
    checkOutput("timeout_no_valid", validCount - v0, 0);
    checkOutput("timeout_dosample", doSampleCount, 1);
    samplerOn = 1'b1;

    $display("[TB] scenario 4: illegal lengths");
    for (int i = 0; i < 2; i++) begin
      doSampleCount = 0;
      @(posedge clk);
      #1;
      start   = 1'b1;
      numQuad = 6'(badLens[i]);
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      checkOutput("len_err_flag", errLen, 1);
      checkOutput("len_err_idle", busy, 0);
      repeat (5) @(negedge clk);
      checkOutput("len_err_no_trigger", doSampleCount, 0);
    end
    applyStimulus(10, 3, 1'b0, 1'b1, 1'b0);

    $display("[TB] scenario 5: reset mid-stream");
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    pushExpected(20);
    @(posedge clk);
    #1;
    start   = 1'b1;
    numQuad = 6'd20;
    @(posedge clk);
    #1 start = 1'b0;
    guard = 0;
    while (beatIdx < 5 && guard < 500) begin
      @(posedge clk);
      guard++;
    end
    checkOutput("reached_data", beatIdx >= 5, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    expQ.delete();
    modelSeq = 16'd0;
    #1;
    checkOutput("async_reset_ctrl", {doSample, txValid, txLast, busy, errTimeout, errLen}, 0);
    checkOutput("async_reset_data", txData, 0);
    checkOutput("async_reset_addr", blkAddr, 0);
    checkOutput("async_reset_seq", seq, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (8) @(posedge clk);
    applyStimulus(12, 4, 1'b1, 1'b1, 1'b0);

    $display("[TB] scenario 6: sequence wrap");
    @(negedge clk);
    force dut.r_seq = 16'hFFFF;
    @(negedge clk);
    release dut.r_seq;
    @(negedge clk);
    checkOutput("seq_preloaded", seq, 16'hFFFF);
    modelSeq = 16'hFFFF;
    applyStimulus(5, 3, 1'b0, 1'b1, 1'b0);
    checkOutput("wrap_header_hi", firstData[31:16], 16'hFFFF);
    checkOutput("seq_wrapped", seq, 0);

    repeat (4) @(posedge clk);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/rt_block_streamer.md
RT_BLOCK_STREAMER -- requirements
Module: rt_block_streamer

Interface
REQ-001 Parameter TIMEOUT_CYC, default 16: max cycles from doSample to sampler completion before abort.
REQ-002 Parameter MAX_QUAD, default 32: largest legal sampled-block length, in quadlets.
REQ-003 clk  in  1  system clock; all logic on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  one-cycle request for one real-time block stream.
REQ-006 num_quad  in  6  sampled quadlets to send (1..MAX_QUAD); latched on accepted start.
REQ-007 doSample  out  1  one-cycle trigger to the sampler.
REQ-008 isBusy  in  1  sampler busy flag.
REQ-009 blk_addr  out  6  sample-buffer read address.
REQ-010 blk_data  in  32  sample-buffer data, combinational from blk_addr.
REQ-011 tx_data  out  32  stream quadlet.
REQ-012 tx_valid  out  1  tx_data valid.
REQ-013 tx_ready  in  1  downstream accepts when tx_valid and tx_ready are both high.
REQ-014 tx_last  out  1  marks the checksum quadlet.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 err_timeout  out  1  sticky sampler-timeout flag.
REQ-017 err_len  out  1  sticky illegal-length flag.
REQ-018 seq  out  16  count of completed streams.

Function
REQ-019 States SHALL be IDLE, TRIG, WAIT_HI, WAIT_LO, HDR, DATA, CSUM.
REQ-020 IDLE: start with num_quad in 1..MAX_QUAD -> TRIG, latch length, clear both error flags; otherwise set err_len and stay in IDLE.
REQ-021 start SHALL be ignored outside IDLE.
REQ-022 TRIG: doSample high for exactly one cycle, then WAIT_HI.
REQ-023 WAIT_HI: isBusy high -> WAIT_LO.
REQ-024 WAIT_LO: isBusy low -> HDR; blk_addr holds 0.
REQ-025 Timeout counter: cleared in TRIG, counts in WAIT_HI/WAIT_LO; on reaching TIMEOUT_CYC, set err_timeout and go to IDLE with no stream output.
REQ-026 HDR: tx_data = {seq, 10'd0, latched num_quad}, tx_valid high.
REQ-027 DATA: quadlet k (k = 0..num_quad-1) is tx_data = blk_data at blk_addr = k.
REQ-028 tx_data SHALL be registered; blk_addr advances only when the current quadlet is accepted, so the next quadlet is presented on the following cycle.
REQ-029 Stall: while tx_valid && !tx_ready, tx_data, tx_last and blk_addr SHALL hold.
REQ-030 Zero-bubble: with tx_ready held high, one quadlet is transferred per cycle from HDR through CSUM.
REQ-031 Checksum: 32-bit modulo-2^32 sum of the header and every data quadlet, accumulated at acceptance.
REQ-032 CSUM: tx_data = checksum, tx_last high; on acceptance, seq increments (wraps 0xFFFF -> 0) and state returns to IDLE.
REQ-033 Total stream length SHALL be num_quad + 2 quadlets.
REQ-034 Undefined state encodings SHALL go to IDLE.

Reset
REQ-035 On reset low, SHALL immediately force state IDLE.
REQ-036 On reset low, SHALL drive all outputs, seq, checksum and counters to 0; an in-flight stream is dropped, not resumed.

Structure
REQ-037 State encodings and the header-layout constants SHALL live in Constants.v, shared with the Firewire and Ethernet packet builders.
REQ-038 The checksum accumulator is one natural sub-module, rt_csum_acc (clear, add-enable, 32-bit data, 32-bit sum).

Verification
REQ-039 Scenario 1: num_quad=28, tx_ready high, sampler busy 5 cycles -> 30 quadlets in 30 consecutive cycles; header 0x0000001C; tx_last on the 30th quadlet only; checksum matches the model.
REQ-040 Scenario 2: same as scenario 1 with tx_ready toggled by a random 50% pattern -> identical 30-quadlet sequence, data stable during stalls.
REQ-041 Scenario 3: isBusy never rises -> err_timeout=1 after 16 cycles, no tx_valid, busy=0, seq unchanged.
REQ-042 Scenario 4: start with num_quad=0, then with num_quad=33 -> err_len=1 each time, doSample never pulses; next legal start clears err_len.
REQ-043 Scenario 5: reset asserted mid-DATA -> all outputs 0 asynchronously; next start produces a full stream with seq unchanged.
REQ-044 Scenario 6: preload seq=0xFFFF, complete one stream -> header upper half 0xFFFF, seq becomes 0x0000 afterwards.
